// File: rtl/synth_ctrl_pkg.sv
// Shared definitions for the synth control register map
// and the note event master.
package synth_ctrl_pkg;

  localparam logic [5:0] KEY_BASE_ADDR  = 6'd32;
  localparam logic [5:0] FREQ_BASE_ADDR = 6'd40;
  localparam logic [5:0] AMP1_BASE_ADDR = 6'd48;
  localparam logic [5:0] AMP0_BASE_ADDR = 6'd56;

  localparam int unsigned SHARED_REG_FIRST = 0;
  localparam int unsigned SHARED_REG_LAST  = 19;

  typedef logic [2:0] voice_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_WR_KEYOFF,
    ST_WR_FREQ,
    ST_WR_AMP1,
    ST_WR_AMP0,
    ST_WR_KEYON,
    ST_OFF_HOLD
  } nem_state_t;

  typedef enum logic [1:0] {
    SEQ_FRESH,
    SEQ_RETRIG,
    SEQ_OFF,
    SEQ_NONE
  } seq_kind_t;

  function automatic logic [5:0] reg_addr(
    input logic [5:0] base,
    input voice_t     v
  );
    return base + {3'b000, v};
  endfunction

endpackage

// File: rtl/note_event_master_if.sv
// Event stream and Avalon-MM write bus bundles
// for the note event master.
interface nem_ev_if;
  logic        EV_VALID;
  logic        EV_READY;
  logic        EV_ON;
  logic [6:0]  EV_NOTE;
  logic [15:0] EV_AMP1;
  logic [15:0] EV_AMP0;

  modport master (
    output EV_VALID, EV_ON, EV_NOTE,
    output EV_AMP1, EV_AMP0,
    input  EV_READY
  );
  modport slave (
    input  EV_VALID, EV_ON, EV_NOTE,
    input  EV_AMP1, EV_AMP0,
    output EV_READY
  );
endinterface

interface nem_avm_if;
  logic [5:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic        AVM_WRITE;
  logic        AVM_READ;
  logic        AVM_CS;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR, AVM_BYTE_EN, AVM_WRITE,
    output AVM_READ, AVM_CS, AVM_WRITEDATA,
    input  AVM_WAITREQUEST
  );
  modport slave (
    input  AVM_ADDR, AVM_BYTE_EN, AVM_WRITE,
    input  AVM_READ, AVM_CS, AVM_WRITEDATA,
    output AVM_WAITREQUEST
  );
endinterface

// File: rtl/voice_allocator.sv
// Picks the target voice and write sequence for one event;
// owns the round-robin steal pointer.
module voice_allocator
  import synth_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  on,
  input  logic [6:0]            note,
  input  logic [NUM_VOICES-1:0] active,
  input  logic [6:0]            notes [NUM_VOICES],
  output voice_t                voice,
  output seq_kind_t             kind
);

  voice_t ptr;
  voice_t hit_v;
  voice_t free_v;
  logic   hit;
  logic   free;
  logic   steal;

  // Descending scan so the lowest index wins.
  always_comb begin
    hit    = 1'b0;
    hit_v  = '0;
    free   = 1'b0;
    free_v = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && notes[i] == note) begin
        hit   = 1'b1;
        hit_v = 3'(i);
      end
      if (!active[i]) begin
        free   = 1'b1;
        free_v = 3'(i);
      end
    end
  end

  assign steal = on && !hit && !free;

  always_comb begin
    voice = '0;
    kind  = SEQ_NONE;
    unique case (1'b1)
      on && hit: begin
        voice = hit_v;
        kind  = SEQ_RETRIG;
      end
      on && !hit && free: begin
        voice = free_v;
        kind  = SEQ_FRESH;
      end
      steal: begin
        voice = ptr;
        kind  = SEQ_RETRIG;
      end
      !on && hit: begin
        voice = hit_v;
        kind  = SEQ_OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (step && steal) begin
      ptr <= (ptr == 3'(NUM_VOICES - 1)) ? '0 : ptr + 3'd1;
    end
  end

endmodule

// File: rtl/note_event_master.sv
// Turns note-on/off events into ordered Avalon-MM writes
// to the per-voice FREQ/AMP1/AMP0/KEY registers.
module note_event_master
  import synth_ctrl_pkg::*;
#(
  parameter int         NUM_VOICES = 8,
  parameter logic [5:0] KEY_BASE   = KEY_BASE_ADDR,
  parameter logic [5:0] FREQ_BASE  = FREQ_BASE_ADDR,
  parameter logic [5:0] AMP1_BASE  = AMP1_BASE_ADDR,
  parameter logic [5:0] AMP0_BASE  = AMP0_BASE_ADDR
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  nem_ev_if.slave               ev,
  nem_avm_if.master             avm,
  output logic [NUM_VOICES-1:0] VOICE_ACTIVE,
  output logic [15:0]           DROP_CNT
);

  nem_state_t            state;
  logic                  ready_q;
  logic                  wr_q;
  logic [5:0]            addr_q;
  logic [31:0]           data_q;
  logic                  on_q;
  logic [6:0]            note_q;
  logic [15:0]           amp1_q;
  logic [15:0]           amp0_q;
  voice_t                v_q;
  seq_kind_t             seq_q;
  logic [NUM_VOICES-1:0] active_q;
  logic [15:0]           drop_q;
  logic [6:0]            notes [NUM_VOICES];
  voice_t                alloc_v;
  seq_kind_t             alloc_kind;
  logic                  done;

  voice_allocator #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .step   (state == ST_ALLOC),
    .on     (on_q),
    .note   (note_q),
    .active (active_q),
    .notes  (notes),
    .voice  (alloc_v),
    .kind   (alloc_kind)
  );

  assign ev.EV_READY         = ready_q;
  assign avm.AVM_WRITE       = wr_q;
  assign avm.AVM_CS          = wr_q;
  assign avm.AVM_READ        = 1'b0;
  assign avm.AVM_BYTE_EN     = 4'hF;
  assign avm.AVM_ADDR        = addr_q;
  assign avm.AVM_WRITEDATA   = data_q;
  assign VOICE_ACTIVE        = active_q;
  assign DROP_CNT            = drop_q;
  assign done                = !avm.AVM_WAITREQUEST;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      on_q     <= 1'b0;
      note_q   <= '0;
      amp1_q   <= '0;
      amp0_q   <= '0;
      v_q      <= '0;
      seq_q    <= SEQ_NONE;
      active_q <= '0;
      drop_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) notes[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ready_q && ev.EV_VALID) begin
            on_q    <= ev.EV_ON;
            note_q  <= ev.EV_NOTE;
            amp1_q  <= ev.EV_AMP1;
            amp0_q  <= ev.EV_AMP0;
            ready_q <= 1'b0;
            state   <= ST_ALLOC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_ALLOC: begin
          v_q   <= alloc_v;
          seq_q <= alloc_kind;
          unique case (alloc_kind)
            SEQ_FRESH: begin
              wr_q   <= 1'b1;
              addr_q <= reg_addr(FREQ_BASE, alloc_v);
              data_q <= {25'd0, note_q};
              state  <= ST_WR_FREQ;
            end
            SEQ_RETRIG, SEQ_OFF: begin
              wr_q   <= 1'b1;
              addr_q <= reg_addr(KEY_BASE, alloc_v);
              data_q <= '0;
              state  <= ST_WR_KEYOFF;
            end
            default: begin
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
              ready_q <= 1'b1;
              state   <= ST_IDLE;
            end
          endcase
        end
        ST_WR_KEYOFF: if (done) begin
          if (seq_q == SEQ_OFF) begin
            active_q[v_q] <= 1'b0;
            wr_q          <= 1'b0;
            state         <= ST_OFF_HOLD;
          end else begin
            addr_q <= reg_addr(FREQ_BASE, v_q);
            data_q <= {25'd0, note_q};
            state  <= ST_WR_FREQ;
          end
        end
        ST_WR_FREQ: if (done) begin
          addr_q <= reg_addr(AMP1_BASE, v_q);
          data_q <= {16'd0, amp1_q};
          state  <= ST_WR_AMP1;
        end
        ST_WR_AMP1: if (done) begin
          addr_q <= reg_addr(AMP0_BASE, v_q);
          data_q <= {16'd0, amp0_q};
          state  <= ST_WR_AMP0;
        end
        ST_WR_AMP0: if (done) begin
          addr_q <= reg_addr(KEY_BASE, v_q);
          data_q <= 32'd1;
          state  <= ST_WR_KEYON;
        end
        ST_WR_KEYON: if (done) begin
          notes[v_q]    <= note_q;
          active_q[v_q] <= 1'b1;
          wr_q          <= 1'b0;
          ready_q       <= 1'b1;
          state         <= ST_IDLE;
        end
        // Release settles one cycle before the next event.
        ST_OFF_HOLD: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_event_master.sv
// Directed bench for note_event_master: allocation, stealing,
// note-off, wait states and mid-sequence reset.
module tb_note_event_master;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  voice_active;
  logic [15:0] drop_cnt;

  nem_ev_if  ev();
  nem_avm_if avm();

  note_event_master dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ev           (ev),
    .avm          (avm),
    .VOICE_ACTIVE (voice_active),
    .DROP_CNT     (drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  hs = 0;
  int  checks = 0;
  int  failures = 0;
  int  rdy;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET_N && avm.AVM_WRITE === 1'b1 && avm.AVM_WAITREQUEST === 1'b0)
      wq.push_back('{avm.AVM_ADDR, avm.AVM_WRITEDATA, cyc});
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [5:0] a,
                           input logic [31:0] d, input int rel);
    wr_t w;
    chk({tag, "_present"}, wq.size() > 0, 1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk({tag, "_addr_data"}, {w.a, w.d}, {a, d});
      if (rel >= 0) chk({tag, "_cycle"}, w.c - hs, rel);
    end
  endtask

  task automatic hs_event(input logic on, input logic [6:0] n,
                          input logic [15:0] a1, input logic [15:0] a0);
    int k = 0;
    while (ev.EV_READY !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("ready_before_event", ev.EV_READY, 1);
    ev.EV_VALID = 1'b1;
    ev.EV_ON    = on;
    ev.EV_NOTE  = n;
    ev.EV_AMP1  = a1;
    ev.EV_AMP0  = a0;
    hs = cyc;
    tick();
    ev.EV_VALID = 1'b0;
    ev.EV_ON    = ~on;
    ev.EV_NOTE  = 7'h55;
    ev.EV_AMP1  = 16'hDEAD;
    ev.EV_AMP0  = 16'hBEEF;
  endtask

  task automatic wait_ready(output int r);
    int k = 0;
    while (ev.EV_READY !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    r = cyc - hs;
  endtask

  task automatic send(input logic on, input logic [6:0] n,
                      input logic [15:0] a1, input logic [15:0] a0);
    hs_event(on, n, a1, a0);
    wait_ready(rdy);
  endtask

  initial begin
    avm.AVM_WAITREQUEST = 1'b0;
    ev.EV_VALID = 1'b0;
    ev.EV_ON    = 1'b0;
    ev.EV_NOTE  = '0;
    ev.EV_AMP1  = '0;
    ev.EV_AMP0  = '0;

    #12;
    chk("rst_ready", ev.EV_READY, 0);
    chk("rst_write", avm.AVM_WRITE, 0);
    chk("rst_cs", avm.AVM_CS, 0);
    chk("rst_read", avm.AVM_READ, 0);
    chk("rst_addr", avm.AVM_ADDR, 0);
    chk("rst_data", avm.AVM_WRITEDATA, 0);
    chk("rst_be", avm.AVM_BYTE_EN, 4'hF);
    chk("rst_active", voice_active, 0);
    chk("rst_drop", drop_cnt, 0);
    RESET_N = 1'b1;
    tick();
    chk("rst_release_ready", ev.EV_READY, 1);

    hs_event(1'b1, 7'd60, 16'h4000, 16'h2000);
    chk("alloc_bus_idle", avm.AVM_WRITE, 0);
    wait_ready(rdy);
    chk("on60_latency", rdy, 6);
    expect_wr("on60_freq", 6'd40, 32'd60, 2);
    expect_wr("on60_amp1", 6'd48, 32'h4000, 3);
    expect_wr("on60_amp0", 6'd56, 32'h2000, 4);
    expect_wr("on60_keyon", 6'd32, 32'd1, 5);
    chk("on60_active", voice_active, 8'h01);
    chk("on60_no_extra", wq.size(), 0);

    for (int i = 1; i < 8; i++) begin
      send(1'b1, 7'(60 + i), 16'(16'h1000 + i), 16'(16'h0800 + i));
      chk("fill_latency", rdy, 6);
      expect_wr("fill_freq", 6'(40 + i), 32'(60 + i), 2);
      expect_wr("fill_amp1", 6'(48 + i), 32'(16'h1000 + i), 3);
      expect_wr("fill_amp0", 6'(56 + i), 32'(16'h0800 + i), 4);
      expect_wr("fill_keyon", 6'(32 + i), 32'd1, 5);
    end
    chk("fill_active", voice_active, 8'hFF);

    send(1'b1, 7'd64, 16'h1111, 16'h2222);
    chk("retrig_latency", rdy, 7);
    expect_wr("retrig_keyoff", 6'd36, 32'd0, 2);
    expect_wr("retrig_freq", 6'd44, 32'd64, 3);
    expect_wr("retrig_amp1", 6'd52, 32'h1111, 4);
    expect_wr("retrig_amp0", 6'd60, 32'h2222, 5);
    expect_wr("retrig_keyon", 6'd36, 32'd1, 6);
    chk("retrig_active", voice_active, 8'hFF);
    chk("retrig_no_extra", wq.size(), 0);

    send(1'b0, 7'd61, 16'h0, 16'h0);
    chk("off61_latency", rdy, 4);
    expect_wr("off61_keyoff", 6'd33, 32'd0, 2);
    chk("off61_active", voice_active, 8'hFD);
    chk("off61_no_extra", wq.size(), 0);

    send(1'b0, 7'd99, 16'h0, 16'h0);
    chk("off99_latency", rdy, 2);
    chk("off99_no_bus", wq.size(), 0);
    chk("off99_drop", drop_cnt, 1);
    chk("off99_active", voice_active, 8'hFD);

    send(1'b1, 7'd72, 16'h0072, 16'h0027);
    chk("on72_latency", rdy, 6);
    expect_wr("on72_freq", 6'd41, 32'd72, 2);
    expect_wr("on72_amp1", 6'd49, 32'h0072, 3);
    expect_wr("on72_amp0", 6'd57, 32'h0027, 4);
    expect_wr("on72_keyon", 6'd33, 32'd1, 5);
    chk("on72_active", voice_active, 8'hFF);

    send(1'b1, 7'd73, 16'h0073, 16'h0037);
    chk("steal0_latency", rdy, 7);
    expect_wr("steal0_keyoff", 6'd32, 32'd0, 2);
    expect_wr("steal0_freq", 6'd40, 32'd73, 3);
    expect_wr("steal0_amp1", 6'd48, 32'h0073, 4);
    expect_wr("steal0_amp0", 6'd56, 32'h0037, 5);
    expect_wr("steal0_keyon", 6'd32, 32'd1, 6);

    send(1'b1, 7'd74, 16'h0074, 16'h0047);
    chk("steal1_latency", rdy, 7);
    expect_wr("steal1_keyoff", 6'd33, 32'd0, 2);
    expect_wr("steal1_freq", 6'd41, 32'd74, 3);
    expect_wr("steal1_amp1", 6'd49, 32'h0074, 4);
    expect_wr("steal1_amp0", 6'd57, 32'h0047, 5);
    expect_wr("steal1_keyon", 6'd33, 32'd1, 6);
    chk("steal_active", voice_active, 8'hFF);

    hs_event(1'b1, 7'd80, 16'h0080, 16'h0008);
    for (int k = 0; k < 4; k++) tick();
    chk("mid_amp0_addr", avm.AVM_ADDR, 6'd58);
    chk("mid_amp0_write", avm.AVM_WRITE, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_write", avm.AVM_WRITE, 0);
    chk("mid_rst_cs", avm.AVM_CS, 0);
    chk("mid_rst_active", voice_active, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_ready", ev.EV_READY, 0);
    #2;
    RESET_N = 1'b1;
    wq.delete();
    tick();
    chk("mid_rst_release_ready", ev.EV_READY, 1);

    hs_event(1'b1, 7'd60, 16'h4000, 16'h2000);
    tick();
    chk("wait_freq_addr", avm.AVM_ADDR, 6'd40);
    tick();
    avm.AVM_WAITREQUEST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("wait_hold_addr", avm.AVM_ADDR, 6'd48);
      chk("wait_hold_data", avm.AVM_WRITEDATA, 32'h4000);
      chk("wait_hold_write", avm.AVM_WRITE, 1);
      tick();
    end
    avm.AVM_WAITREQUEST = 1'b0;
    chk("wait_last_addr", avm.AVM_ADDR, 6'd48);
    chk("wait_last_data", avm.AVM_WRITEDATA, 32'h4000);
    wait_ready(rdy);
    chk("wait_latency", rdy, 9);
    expect_wr("wait_freq", 6'd40, 32'd60, 2);
    expect_wr("wait_amp1", 6'd48, 32'h4000, 6);
    expect_wr("wait_amp0", 6'd56, 32'h2000, 7);
    expect_wr("wait_keyon", 6'd32, 32'd1, 8);
    chk("wait_active", voice_active, 8'h01);
    chk("wait_no_extra", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
